// File: rtl/anycore_l15_resp_encoder_pkg.sv
// Shared constants for the L1.5-to-AnyCore response encoder: FSM states,
// L1.5 return types and line geometry.
package anycore_l15_resp_encoder_pkg;

  localparam int unsigned LINE_W                 = 256;
  localparam int unsigned WORD_W                 = 64;
  localparam int unsigned ICACHE_BLOCK_ADDR_BITS = 27;
  localparam int unsigned DCACHE_BLOCK_ADDR_BITS = 27;

  // Return-type codes as encoded by the L1.5 (iop.h)
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    ACK     = 2'd2,
    DRAIN   = 2'd3
  } enc_state_t;

  function automatic logic rtype_known(input logic [3:0] rt);
    logic known_s;
    case (rt)
      LOAD_RET, IFILL_RET, EVICT_REQ, ST_ACK, INT_RET: known_s = 1'b1;
      default:                                         known_s = 1'b0;
    endcase
    return known_s;
  endfunction

endpackage

// File: rtl/anycore_l15_resp_encoder_if.sv
// Bundle of L1.5 response port and AnyCore memory-side signals seen by the
// response encoder; the encoder uses the slave view.
interface anycore_l15_resp_encoder_if;
  import anycore_l15_resp_encoder_pkg::*;

  logic                              l15_transducer_val;
  logic [3:0]                        l15_transducer_returntype;
  logic [WORD_W-1:0]                 l15_transducer_data_0;
  logic [WORD_W-1:0]                 l15_transducer_data_1;
  logic [WORD_W-1:0]                 l15_transducer_data_2;
  logic [WORD_W-1:0]                 l15_transducer_data_3;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_ic2mem_reqaddr;
  logic                              anycore_ic2mem_reqvalid;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] anycore_dc2mem_ldaddr;
  logic                              anycore_dc2mem_ldvalid;
  logic                              anycore_dc2mem_stvalid;
  logic                              transducer_l15_req_ack;
  logic                              anycore_mem2ic_respvalid;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2ic_respaddr;
  logic [LINE_W-1:0]                 anycore_mem2ic_data;
  logic                              anycore_mem2dc_ldvalid;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2dc_ldaddr;
  logic [LINE_W-1:0]                 anycore_mem2dc_lddata;
  logic                              anycore_mem2dc_stcomplete;
  logic                              anycore_stbuf_empty;
  logic                              encoder_err;

  modport master (
    output l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_data_2, l15_transducer_data_3,
           anycore_ic2mem_reqaddr, anycore_ic2mem_reqvalid,
           anycore_dc2mem_ldaddr, anycore_dc2mem_ldvalid, anycore_dc2mem_stvalid,
    input  transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_mem2ic_respaddr,
           anycore_mem2ic_data, anycore_mem2dc_ldvalid, anycore_mem2dc_ldaddr,
           anycore_mem2dc_lddata, anycore_mem2dc_stcomplete, anycore_stbuf_empty,
           encoder_err
  );

  modport slave (
    input  l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_data_2, l15_transducer_data_3,
           anycore_ic2mem_reqaddr, anycore_ic2mem_reqvalid,
           anycore_dc2mem_ldaddr, anycore_dc2mem_ldvalid, anycore_dc2mem_stvalid,
    output transducer_l15_req_ack, anycore_mem2ic_respvalid, anycore_mem2ic_respaddr,
           anycore_mem2ic_data, anycore_mem2dc_ldvalid, anycore_mem2dc_ldaddr,
           anycore_mem2dc_lddata, anycore_mem2dc_stcomplete, anycore_stbuf_empty,
           encoder_err
  );

endinterface

// File: rtl/anycore_l15_resp_encoder_byteswap64.sv
// Byte reversal of one 64-bit word (byte 0 <-> byte 7); only present when
// ANYCORE_RESP_BYTESWAP_EN is defined, which is the only build that uses it.
`ifdef ANYCORE_RESP_BYTESWAP_EN
module anycore_byteswap64 (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign dout[8*b +: 8] = din[8*(7-b) +: 8];
  end

endmodule
`endif

// File: rtl/anycore_l15_resp_encoder.sv
// Turns L1.5 responses into AnyCore fill/store-complete pulses and acks them.
// Define ANYCORE_RESP_BYTESWAP_EN to byte-reverse each 64-bit payload word.
module anycore_l15_resp_encoder
  import anycore_l15_resp_encoder_pkg::*;
#(
  parameter int unsigned ST_CNT_W = 3
) (
  input logic                       clk,
  input logic                       rst,
  anycore_l15_resp_encoder_if.slave bus
);

  localparam logic [ST_CNT_W-1:0] CNT_ONE = {{(ST_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ST_CNT_W-1:0] CNT_MAX = {ST_CNT_W{1'b1}};

  enc_state_t                        state_r, state_nxt_s;
  logic [3:0]                        rtype_r;
  logic [LINE_W-1:0]                 data_r, data_fmt_s;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ifill_addr_r, ic_addr_r;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_addr_r, ld_out_addr_r;
  logic                              ifill_pend_r, ld_pend_r;
  logic [ST_CNT_W-1:0]               st_cnt_r, st_cnt_nxt_s;
  logic [LINE_W-1:0]                 ic_data_r, ld_data_r;
  logic                              ack_r, ic_valid_r, ld_valid_r, st_done_r;
  logic                              stbuf_empty_r, err_r;
  logic                              accept_s, deliver_s, ack_s;
  logic                              dlv_ic_s, dlv_ld_s, dlv_st_s;
  logic                              cnt_err_s, err_set_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    deliver_s   = 1'b0;
    ack_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.l15_transducer_val) begin
          accept_s    = 1'b1;
          state_nxt_s = DELIVER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DELIVER: begin
        deliver_s   = 1'b1;
        state_nxt_s = ACK;
      end
      ACK: begin
        ack_s       = 1'b1;
        state_nxt_s = DRAIN;
      end
      DRAIN: begin
        if (bus.l15_transducer_val) state_nxt_s = DRAIN;
        else                        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Return-type decode, store counter update and error detection
  always_comb begin
    dlv_ic_s     = deliver_s && (rtype_r == IFILL_RET);
    dlv_ld_s     = deliver_s && (rtype_r == LOAD_RET);
    dlv_st_s     = deliver_s && (rtype_r == ST_ACK);
    st_cnt_nxt_s = st_cnt_r;
    cnt_err_s    = 1'b0;
    if (bus.anycore_dc2mem_stvalid && !dlv_st_s) begin
      if (st_cnt_r == CNT_MAX) cnt_err_s    = 1'b1;
      else                     st_cnt_nxt_s = st_cnt_r + CNT_ONE;
    end else if (dlv_st_s && !bus.anycore_dc2mem_stvalid) begin
      if (st_cnt_r == '0) cnt_err_s    = 1'b1;
      else                st_cnt_nxt_s = st_cnt_r - CNT_ONE;
    end else begin
      st_cnt_nxt_s = st_cnt_r;
    end
    err_set_s = cnt_err_s
              || (deliver_s && !rtype_known(rtype_r))
              || (dlv_ic_s && !ifill_pend_r)
              || (dlv_ld_s && !ld_pend_r);
  end

`ifdef ANYCORE_RESP_BYTESWAP_EN
  for (genvar w = 0; w < 4; w++) begin : g_swap
    anycore_byteswap64 u_swap (
      .din  (data_r[WORD_W*w +: WORD_W]),
      .dout (data_fmt_s[WORD_W*w +: WORD_W])
    );
  end
`else
  assign data_fmt_s = data_r;
`endif

  // Response latch and miss-address capture; a fresh capture beats a delivery
  always_ff @(posedge clk) begin
    if (rst) begin
      rtype_r      <= 4'd0;
      data_r       <= '0;
      ifill_addr_r <= '0;
      ifill_pend_r <= 1'b0;
      ld_addr_r    <= '0;
      ld_pend_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        rtype_r <= bus.l15_transducer_returntype;
        data_r  <= {bus.l15_transducer_data_3, bus.l15_transducer_data_2,
                    bus.l15_transducer_data_1, bus.l15_transducer_data_0};
      end
      if (bus.anycore_ic2mem_reqvalid) begin
        ifill_addr_r <= bus.anycore_ic2mem_reqaddr;
        ifill_pend_r <= 1'b1;
      end else if (dlv_ic_s) begin
        ifill_pend_r <= 1'b0;
      end
      if (bus.anycore_dc2mem_ldvalid) begin
        ld_addr_r <= bus.anycore_dc2mem_ldaddr;
        ld_pend_r <= 1'b1;
      end else if (dlv_ld_s) begin
        ld_pend_r <= 1'b0;
      end
    end
  end

  // Registered outputs: one-cycle pulses, held fill data, store count, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r         <= 1'b0;
      ic_valid_r    <= 1'b0;
      ld_valid_r    <= 1'b0;
      st_done_r     <= 1'b0;
      ic_addr_r     <= '0;
      ic_data_r     <= '0;
      ld_out_addr_r <= '0;
      ld_data_r     <= '0;
      st_cnt_r      <= '0;
      stbuf_empty_r <= 1'b1;
      err_r         <= 1'b0;
    end else begin
      ack_r         <= ack_s;
      ic_valid_r    <= dlv_ic_s;
      ld_valid_r    <= dlv_ld_s;
      st_done_r     <= dlv_st_s;
      st_cnt_r      <= st_cnt_nxt_s;
      stbuf_empty_r <= (st_cnt_nxt_s == '0);
      if (dlv_ic_s) begin
        ic_addr_r <= ifill_addr_r;
        ic_data_r <= data_fmt_s;
      end
      if (dlv_ld_s) begin
        ld_out_addr_r <= ld_addr_r;
        ld_data_r     <= data_fmt_s;
      end
      if (err_set_s) err_r <= 1'b1;
    end
  end

  assign bus.transducer_l15_req_ack    = ack_r;
  assign bus.anycore_mem2ic_respvalid  = ic_valid_r;
  assign bus.anycore_mem2ic_respaddr   = ic_addr_r;
  assign bus.anycore_mem2ic_data       = ic_data_r;
  assign bus.anycore_mem2dc_ldvalid    = ld_valid_r;
  assign bus.anycore_mem2dc_ldaddr     = ld_out_addr_r;
  assign bus.anycore_mem2dc_lddata     = ld_data_r;
  assign bus.anycore_mem2dc_stcomplete = st_done_r;
  assign bus.anycore_stbuf_empty       = stbuf_empty_r;
  assign bus.encoder_err               = err_r;

endmodule

// File: tb/tb_anycore_l15_resp_encoder.sv
// Directed bench for anycore_l15_resp_encoder: fills, stores, drops, drain
// behaviour, reset mid-delivery and sticky error; inputs and samples on negedge.
module tb_anycore_l15_resp_encoder;
  import anycore_l15_resp_encoder_pkg::*;

  localparam logic [63:0] D0 = 64'h0011223344556677;
  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D3 = 64'h8000000000000001;
`ifdef ANYCORE_RESP_BYTESWAP_EN
  localparam logic [63:0]  EXP_W0   = 64'h7766554433221100;
  localparam logic [255:0] EXP_LINE = {64'h0100000000000080, 64'h0DF0FECAEFBEADDE,
                                       64'hEFCDAB8967452301, 64'h7766554433221100};
`else
  localparam logic [63:0]  EXP_W0   = 64'h0011223344556677;
  localparam logic [255:0] EXP_LINE = {64'h8000000000000001, 64'hDEADBEEFCAFEF00D,
                                       64'h0123456789ABCDEF, 64'h0011223344556677};
`endif

  logic clk;
  logic rst;
  int   checks_cnt;
  int   errors_cnt;

  // snapshot of one response transaction
  logic         snap_ic_s, snap_ld_s, snap_st_s, snap_empty_s, snap_ack_early_s;
  logic         snap_ack_s, snap_late_s, snap_ack_late_s, snap_extra_s;
  logic [26:0]  snap_ic_addr_s, snap_ld_addr_s;
  logic [255:0] snap_ic_data_s, snap_ld_data_s;

  anycore_l15_resp_encoder_if bus ();

  anycore_l15_resp_encoder #(.ST_CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one response; hold val `hold` extra cycles after the L1.5 drop point
  task automatic send(input logic [3:0] rt, input logic st_dlv, input int hold);
    bus.l15_transducer_val        = 1'b1;
    bus.l15_transducer_returntype = rt;
    bus.l15_transducer_data_0     = D0;
    bus.l15_transducer_data_1     = D1;
    bus.l15_transducer_data_2     = D2;
    bus.l15_transducer_data_3     = D3;
    step();
    bus.anycore_dc2mem_stvalid = st_dlv;
    step();
    bus.anycore_dc2mem_stvalid = 1'b0;
    snap_ic_s        = bus.anycore_mem2ic_respvalid;
    snap_ld_s        = bus.anycore_mem2dc_ldvalid;
    snap_st_s        = bus.anycore_mem2dc_stcomplete;
    snap_empty_s     = bus.anycore_stbuf_empty;
    snap_ack_early_s = bus.transducer_l15_req_ack;
    snap_ic_addr_s   = bus.anycore_mem2ic_respaddr;
    snap_ld_addr_s   = bus.anycore_mem2dc_ldaddr;
    snap_ic_data_s   = bus.anycore_mem2ic_data;
    snap_ld_data_s   = bus.anycore_mem2dc_lddata;
    step();
    snap_ack_s  = bus.transducer_l15_req_ack;
    snap_late_s = bus.anycore_mem2ic_respvalid | bus.anycore_mem2dc_ldvalid
                | bus.anycore_mem2dc_stcomplete;
    step();
    snap_ack_late_s = bus.transducer_l15_req_ack;
    snap_extra_s    = snap_late_s & 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      snap_extra_s = snap_extra_s | bus.transducer_l15_req_ack | bus.anycore_mem2ic_respvalid
                   | bus.anycore_mem2dc_ldvalid | bus.anycore_mem2dc_stcomplete;
    end
    bus.l15_transducer_val = 1'b0;
    step();
  endtask

  task automatic chk_handshake(input string tag);
    chk({tag, "_ack_early"}, 256'(snap_ack_early_s), 256'd0);
    chk({tag, "_ack"},       256'(snap_ack_s),       256'd1);
    chk({tag, "_ack_1cyc"},  256'(snap_ack_late_s),  256'd0);
    chk({tag, "_no_late"},   256'(snap_late_s),      256'd0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    bus.l15_transducer_val        = 1'b0;
    bus.l15_transducer_returntype = 4'd0;
    bus.l15_transducer_data_0     = 64'd0;
    bus.l15_transducer_data_1     = 64'd0;
    bus.l15_transducer_data_2     = 64'd0;
    bus.l15_transducer_data_3     = 64'd0;
    bus.anycore_ic2mem_reqaddr    = 27'd0;
    bus.anycore_ic2mem_reqvalid   = 1'b0;
    bus.anycore_dc2mem_ldaddr     = 27'd0;
    bus.anycore_dc2mem_ldvalid    = 1'b0;
    bus.anycore_dc2mem_stvalid    = 1'b0;
    step();
    step();
    chk("rst_ack",   256'(bus.transducer_l15_req_ack),    256'd0);
    chk("rst_ic",    256'(bus.anycore_mem2ic_respvalid),  256'd0);
    chk("rst_ld",    256'(bus.anycore_mem2dc_ldvalid),    256'd0);
    chk("rst_st",    256'(bus.anycore_mem2dc_stcomplete), 256'd0);
    chk("rst_empty", 256'(bus.anycore_stbuf_empty),       256'd1);
    chk("rst_err",   256'(bus.encoder_err),               256'd0);
    chk("rst_icdat", bus.anycore_mem2ic_data,             256'd0);
    rst = 1'b0;

    // i-fill with a pending miss
    bus.anycore_ic2mem_reqaddr  = 27'h1A3;
    bus.anycore_ic2mem_reqvalid = 1'b1;
    step();
    bus.anycore_ic2mem_reqvalid = 1'b0;
    send(IFILL_RET, 1'b0, 0);
    chk("if_pulse", 256'(snap_ic_s),      256'd1);
    chk("if_nold",  256'(snap_ld_s),      256'd0);
    chk("if_addr",  256'(snap_ic_addr_s), 256'h1A3);
    chk("if_w0",    256'(snap_ic_data_s[63:0]), 256'(EXP_W0));
    chk("if_line",  snap_ic_data_s,       EXP_LINE);
    chk_handshake("if");
    chk("if_err",   256'(bus.encoder_err), 256'd0);
    chk("if_hold",  bus.anycore_mem2ic_data, EXP_LINE);

    // three stores then three store acks
    for (int i = 0; i < 3; i++) begin
      bus.anycore_dc2mem_stvalid = 1'b1;
      step();
    end
    bus.anycore_dc2mem_stvalid = 1'b0;
    chk("st_busy", 256'(bus.anycore_stbuf_empty), 256'd0);
    for (int i = 0; i < 3; i++) begin
      send(ST_ACK, 1'b0, 0);
      chk("st_pulse", 256'(snap_st_s),    256'd1);
      chk("st_noic",  256'(snap_ic_s),    256'd0);
      chk("st_empty", 256'(snap_empty_s), (i == 2) ? 256'd1 : 256'd0);
      chk_handshake("st");
    end
    chk("st_err", 256'(bus.encoder_err), 256'd0);

    // store issue coinciding with a store-ack delivery leaves count unchanged
    bus.anycore_dc2mem_stvalid = 1'b1;
    step();
    bus.anycore_dc2mem_stvalid = 1'b0;
    send(ST_ACK, 1'b1, 0);
    chk("stx_pulse", 256'(snap_st_s),    256'd1);
    chk("stx_empty", 256'(snap_empty_s), 256'd0);
    send(ST_ACK, 1'b0, 0);
    chk("stx_empty2", 256'(snap_empty_s), 256'd1);
    chk("stx_err",    256'(bus.encoder_err), 256'd0);

    // eviction is dropped but acked
    send(EVICT_REQ, 1'b0, 0);
    chk("ev_nopulse", 256'(snap_ic_s | snap_ld_s | snap_st_s), 256'd0);
    chk_handshake("ev");
    chk("ev_err", 256'(bus.encoder_err), 256'd0);

    // val held after ack: no second delivery until it drops and rises again
    send(INT_RET, 1'b0, 3);
    chk("hold_nopulse", 256'(snap_ic_s | snap_ld_s | snap_st_s), 256'd0);
    chk("hold_quiet",   256'(snap_extra_s), 256'd0);
    bus.anycore_dc2mem_ldaddr  = 27'h2A5A5A5;
    bus.anycore_dc2mem_ldvalid = 1'b1;
    step();
    bus.anycore_dc2mem_ldvalid = 1'b0;
    send(LOAD_RET, 1'b0, 0);
    chk("ld_pulse", 256'(snap_ld_s),      256'd1);
    chk("ld_addr",  256'(snap_ld_addr_s), 256'h2A5A5A5);
    chk("ld_line",  snap_ld_data_s,       EXP_LINE);
    chk_handshake("ld");
    chk("ld_err",   256'(bus.encoder_err), 256'd0);

    // load with nothing pending: still delivered with stale address, error sticks
    send(LOAD_RET, 1'b0, 0);
    chk("ldst_pulse", 256'(snap_ld_s),      256'd1);
    chk("ldst_addr",  256'(snap_ld_addr_s), 256'h2A5A5A5);
    chk("ldst_line",  snap_ld_data_s,       EXP_LINE);
    chk("ldst_err",   256'(bus.encoder_err), 256'd1);
    step();
    step();
    step();
    chk("ldst_sticky", 256'(bus.encoder_err), 256'd1);

    // reset while in DELIVER, then the re-presented fill is handled normally
    bus.l15_transducer_val        = 1'b1;
    bus.l15_transducer_returntype = IFILL_RET;
    step();
    rst = 1'b1;
    step();
    chk("mid_ic",    256'(bus.anycore_mem2ic_respvalid), 256'd0);
    chk("mid_ack",   256'(bus.transducer_l15_req_ack),   256'd0);
    chk("mid_icdat", bus.anycore_mem2ic_data,            256'd0);
    chk("mid_empty", 256'(bus.anycore_stbuf_empty),      256'd1);
    chk("mid_err",   256'(bus.encoder_err),              256'd0);
    rst = 1'b0;
    bus.anycore_ic2mem_reqaddr  = 27'h0B7;
    bus.anycore_ic2mem_reqvalid = 1'b1;
    step();
    bus.anycore_ic2mem_reqvalid = 1'b0;
    step();
    chk("re_pulse", 256'(bus.anycore_mem2ic_respvalid), 256'd1);
    chk("re_addr",  256'(bus.anycore_mem2ic_respaddr),  256'h0B7);
    chk("re_line",  bus.anycore_mem2ic_data,            EXP_LINE);
    step();
    chk("re_ack",   256'(bus.transducer_l15_req_ack),   256'd1);
    step();
    bus.l15_transducer_val = 1'b0;
    step();
    chk("re_err",   256'(bus.encoder_err), 256'd0);

    // unknown return type flags an error
    send(4'hF, 1'b0, 0);
    chk("unk_nopulse", 256'(snap_ic_s | snap_ld_s | snap_st_s), 256'd0);
    chk_handshake("unk");
    chk("unk_err", 256'(bus.encoder_err), 256'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("clr_err", 256'(bus.encoder_err), 256'd0);

    // counter saturation: seventh store fills it, eighth overflows
    bus.anycore_dc2mem_stvalid = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("sat_err0",  256'(bus.encoder_err),         256'd0);
    chk("sat_empty", 256'(bus.anycore_stbuf_empty), 256'd0);
    step();
    bus.anycore_dc2mem_stvalid = 1'b0;
    chk("sat_err1", 256'(bus.encoder_err), 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/anycore_l15_resp_encoder.md
# anycore_l15_resp_encoder

Converts L1.5 transducer responses into AnyCore memory-response pulses: i-cache fills, d-cache load fills, and store completions. Sits between the L1.5 return port and AnyCore, beside the request-side decoder. It matches each response to the outstanding request address and handshakes the response back to the L1.5. It also tracks outstanding store count and drops invalidation/eviction traffic, which AnyCore does not use.

## Interface
Parameters:
- `ST_CNT_W`, default 3: width of the outstanding-store counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `l15_transducer_val`  in  1  response valid; held high until acked.
- `l15_transducer_returntype`  in  4  `LOAD_RET`, `IFILL_RET`, `ST_ACK`, `EVICT_REQ`, `INT_RET` (iop.h).
- `l15_transducer_data_0..3`  in  64 each  response payload; data_0 is the lowest-addressed word.
- `anycore_ic2mem_reqaddr` / `anycore_ic2mem_reqvalid`  in  `ICACHE_BLOCK_ADDR_BITS` / 1  i-miss capture.
- `anycore_dc2mem_ldaddr` / `anycore_dc2mem_ldvalid`  in  `DCACHE_BLOCK_ADDR_BITS` / 1  load-miss capture.
- `anycore_dc2mem_stvalid`  in  1  store issued.
- `transducer_l15_req_ack`  out  1  one-cycle response ack.
- `anycore_mem2ic_respvalid`  out  1  fill pulse.
- `anycore_mem2ic_respaddr`  out  `ICACHE_BLOCK_ADDR_BITS`  fill address.
- `anycore_mem2ic_data`  out  256  fill data.
- `anycore_mem2dc_ldvalid`  out  1  load fill pulse.
- `anycore_mem2dc_ldaddr`  out  `DCACHE_BLOCK_ADDR_BITS`  load fill address.
- `anycore_mem2dc_lddata`  out  256  load fill data.
- `anycore_mem2dc_stcomplete`  out  1  store-complete pulse.
- `anycore_stbuf_empty`  out  1  high when the store count is zero.
- `encoder_err`  out  1  sticky protocol-error flag.

## Operation
- Capture registers: `ifill_addr` loads on `ic2mem_reqvalid`; `ld_addr` loads on `dc2mem_ldvalid`. Each has a pending bit, set on capture and cleared when the matching response is delivered.
- FSM states:
  - IDLE: on `l15_transducer_val`, register returntype and data, go to DELIVER.
  - DELIVER: drive exactly one output pulse selected by returntype:
    - `IFILL_RET`: mem2ic with `ifill_addr`.
    - `LOAD_RET`: mem2dc with `ld_addr`.
    - `ST_ACK`: stcomplete, counter decremented.
    - `EVICT_REQ` / `INT_RET`: no pulse.
    - Then go to ACK.
  - ACK: assert `transducer_l15_req_ack` for one cycle, go to DRAIN.
  - DRAIN: wait for `l15_transducer_val` low, then go to IDLE. A new response is never taken before val has dropped.
- Store counter:
  - +1 on `dc2mem_stvalid`, −1 on delivered `ST_ACK`.
  - Both in the same cycle: counter unchanged.
  - Saturates at max and at 0; increment at max or decrement at 0 sets `encoder_err`.
- Error cases, all setting `encoder_err`:
  - `IFILL_RET` or `LOAD_RET` with its pending bit clear: data still pulsed with the stale address.
  - Unknown returntype.
- `encoder_err` is cleared only by `rst`.
- A capture in the same cycle as delivery of the same type: the new capture wins; the pending bit stays set.

## Timing
- Response val high at cycle N → anycore pulse at N+2 → ack at N+3 → earliest next accept at N+5 (val must drop by N+4).
- Output pulses are exactly one cycle. Data and address are registered and held stable until the next delivery.
- Reset values: all outputs 0 except `anycore_stbuf_empty` = 1. FSM in IDLE, pending bits clear, counter 0.
- Reset mid-operation: return to IDLE with no ack. The L1.5 re-presents the response, which is then handled normally.

## Configuration
- `ANYCORE_RESP_BYTESWAP_EN` defined: each 64-bit data word is byte-reversed (byte 0 ↔ byte 7) before output, matching the big-endian L1.5 payload to little-endian AnyCore.
- Undefined: words pass unmodified.
- Word order is unchanged in both cases.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, DELIVER, ACK, DRAIN).
  - Returntype constants, reused from iop.h.
  - The 256-bit line width constant.
- One sub-module: `anycore_byteswap64`, instantiated ×4 under the macro.

## Test plan
- `ic2mem_reqaddr` = 0x1A3 captured, then `IFILL_RET` with data_0 = 0x0011223344556677 → `mem2ic_respvalid` pulse with respaddr 0x1A3; lowest word 0x7766554433221100 (swap on) or 0x0011223344556677 (swap off); ack one cycle later.
- Three `dc2mem_stvalid` pulses, then three `ST_ACK`s → three stcomplete pulses; `stbuf_empty` goes 0→1 only after the third.
- `LOAD_RET` with no load pending → lddata delivered, `encoder_err` = 1 and stays 1 until `rst`.
- `EVICT_REQ` response → no anycore pulse, ack asserted at N+3.
- `l15_transducer_val` held high for 4 cycles after ack → no second delivery until val drops and rises again.
- `rst` asserted in DELIVER → all outputs 0 next cycle; the re-presented response is delivered normally.
